// File: rtl/dbg_uart_ctrl.sv
// -----------------------------------------------------------------------------
// dbg_uart_ctrl
//
// Debug command controller that sits between the UART byte stream and the
// pipeline debug taps.
//
// Function:
//   * Decodes single-byte commands from the UART receiver:
//       0x72 'r' run, 0x68 'h' halt, 0x73 's' single step, 0x64 'd' dump.
//     Any other byte is ignored.
//   * Gates the CPU clock enable from a run flag and a one-cycle step pulse.
//   * Sequences a framed dump of NUM_WORDS 32-bit debug words to the UART
//     transmitter:
//       HDR, word0[31:24], word0[23:16], ..., word(N-1)[7:0], TRL
//     for a total of 4*NUM_WORDS+2 bytes.
//
// Transmit handshake (single outstanding byte):
//   tx_start is a one-cycle pulse that asks the transmitter to load tx_data.
//   After a pulse, no further tx_start is issued until the transmitter returns
//   a tx_done_tick for that byte. tx_data is held constant from the tx_start
//   cycle up to and including the tx_done_tick cycle. A tx_done_tick that
//   arrives while no byte is outstanding is ignored.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous reset, active-low
//   rx_data      in   [7:0]  received byte, valid while rx_done_tick=1
//   rx_done_tick in   one-cycle pulse per received byte
//   tx_data      out  [7:0]  byte to transmit
//   tx_start     out  one-cycle pulse, transmitter loads tx_data
//   tx_done_tick in   one-cycle pulse, transmitter finished the byte
//   dbg_sel      out  [ADDR_W-1:0]  debug word select to the tap mux
//   dbg_word     in   [31:0] selected debug word, combinational from dbg_sel
//   cpu_clk_en   out  pipeline clock enable (registered)
//   dump_busy    out  high while a dump frame is in progress
//   fsm_state    out  [2:0]  current dump FSM state, for observation only
// -----------------------------------------------------------------------------
module dbg_uart_ctrl #(
    parameter int          NUM_WORDS = 64,
    parameter int          ADDR_W    = 6,
    parameter logic [7:0]  HDR       = 8'hA5,
    parameter logic [7:0]  TRL       = 8'h5A
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done_tick,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_done_tick,
    output logic [ADDR_W-1:0] dbg_sel,
    input  logic [31:0]       dbg_word,
    output logic              cpu_clk_en,
    output logic              dump_busy,
    output logic [2:0]        fsm_state
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [7:0] CMD_RUN  = 8'h72;
    localparam logic [7:0] CMD_HALT = 8'h68;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_DUMP = 8'h64;

    // Index of the last word, one bit wider than dbg_sel so that
    // NUM_WORDS = 2**ADDR_W is represented without truncation.
    localparam logic [ADDR_W:0] LAST_SEL = (ADDR_W + 1)'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HDR_TX    = 3'd1,
        S_WAIT      = 3'd2,
        S_LATCH     = 3'd3,
        S_BYTE_TX   = 3'd4,
        S_TRL_TX    = 3'd5,
        S_DONE_WAIT = 3'd6
    } state_t;

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    logic cmd_run;
    logic cmd_halt;
    logic cmd_step;
    logic cmd_dump;

    assign cmd_run  = rx_done_tick && (rx_data == CMD_RUN);
    assign cmd_halt = rx_done_tick && (rx_data == CMD_HALT);
    assign cmd_step = rx_done_tick && (rx_data == CMD_STEP);
    assign cmd_dump = rx_done_tick && (rx_data == CMD_DUMP);

    // -------------------------------------------------------------------------
    // Run / halt / step control
    // -------------------------------------------------------------------------
    logic run_q;
    logic run_d;
    logic step_q;      // high during the single cycle of an issued step
    logic step_fire;

    always_comb begin
        run_d = run_q;
        if (cmd_run) begin
            run_d = 1'b1;
        end else if (cmd_halt) begin
            run_d = 1'b0;
        end
    end

    // A step is only honoured while halted and when the previous step pulse
    // has already ended, so back-to-back 's' bytes give one pulse each at
    // most and never stretch the enable.
    assign step_fire = cmd_step && !run_q && !step_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            step_q     <= 1'b0;
            cpu_clk_en <= 1'b0;
        end else begin
            run_q      <= run_d;
            step_q     <= step_fire;
            cpu_clk_en <= run_d | step_fire;
        end
    end

    // -------------------------------------------------------------------------
    // Dump FSM: state register
    // -------------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Dump datapath
    // -------------------------------------------------------------------------
    logic        hdr_pend_q;  // the byte in flight is the header
    logic [1:0]  idx_q;       // byte index within the current word, 0 = MSB
    logic [31:0] shadow_q;    // snapshot of the word being sent
    logic        last_word;
    logic [7:0]  cur_byte;

    assign last_word = ({1'b0, dbg_sel} == LAST_SEL);

    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            2'd0: cur_byte = shadow_q[31:24];
            2'd1: cur_byte = shadow_q[23:16];
            2'd2: cur_byte = shadow_q[15:8];
            2'd3: cur_byte = shadow_q[7:0];
            default: cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_pend_q <= 1'b0;
            idx_q      <= 2'd0;
            shadow_q   <= 32'h0;
            dbg_sel    <= '0;
        end else begin
            case (state_q)
                S_HDR_TX: begin
                    hdr_pend_q <= 1'b1;
                end
                S_LATCH: begin
                    // dbg_sel was settled in the previous cycle, so the tap
                    // mux output is stable here.
                    shadow_q <= dbg_word;
                    idx_q    <= 2'd0;
                end
                S_BYTE_TX: begin
                    hdr_pend_q <= 1'b0;
                end
                S_WAIT: begin
                    if (tx_done_tick) begin
                        if (hdr_pend_q) begin
                            dbg_sel <= '0;
                        end else if (idx_q != 2'd3) begin
                            idx_q <= idx_q + 2'd1;
                        end else if (!last_word) begin
                            dbg_sel <= dbg_sel + 1'b1;
                        end
                    end
                end
                S_DONE_WAIT: begin
                    if (tx_done_tick) begin
                        dbg_sel <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Dump FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_dump) begin
                    state_d = S_HDR_TX;
                end
            end
            S_HDR_TX: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (tx_done_tick) begin
                    if (hdr_pend_q) begin
                        state_d = S_LATCH;
                    end else if (idx_q != 2'd3) begin
                        state_d = S_BYTE_TX;
                    end else if (!last_word) begin
                        state_d = S_LATCH;
                    end else begin
                        state_d = S_TRL_TX;
                    end
                end
            end
            S_LATCH: begin
                state_d = S_BYTE_TX;
            end
            S_BYTE_TX: begin
                state_d = S_WAIT;
            end
            S_TRL_TX: begin
                state_d = S_DONE_WAIT;
            end
            S_DONE_WAIT: begin
                if (tx_done_tick) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Dump FSM: outputs
    // -------------------------------------------------------------------------
    // tx_data is decoded from registered state only; in WAIT the header flag,
    // byte index and shadow are all frozen, which keeps the byte steady until
    // tx_done_tick.
    always_comb begin
        tx_start  = 1'b0;
        tx_data   = 8'h00;
        dump_busy = (state_q != S_IDLE);
        case (state_q)
            S_HDR_TX: begin
                tx_start = 1'b1;
                tx_data  = HDR;
            end
            S_WAIT: begin
                tx_data = hdr_pend_q ? HDR : cur_byte;
            end
            S_BYTE_TX: begin
                tx_start = 1'b1;
                tx_data  = cur_byte;
            end
            S_TRL_TX: begin
                tx_start = 1'b1;
                tx_data  = TRL;
            end
            S_DONE_WAIT: begin
                tx_data = TRL;
            end
            default: begin
            end
        endcase
    end

    assign fsm_state = state_q;

endmodule

// File: tb/tb_dbg_uart_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dbg_uart_ctrl
//
// Drives dbg_uart_ctrl with 4 debug words over a 2-bit select (the select
// range is fully used). A transmitter responder returns tx_done_tick a
// programmable number of cycles after each tx_start and records every
// transmitted byte. Expected frames come from a reference model that simply
// lists header, the words MSB first, and trailer.
// -----------------------------------------------------------------------------
module tb_dbg_uart_ctrl;

  localparam int NW = 4;
  localparam int AW = 2;

  // clock / reset
  logic clk;
  logic reset;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // DUT signals
  logic [7:0]    rx_data;
  logic          rx_done_tick;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_done_tick;
  logic [AW-1:0] dbg_sel;
  logic [31:0]   dbg_word;
  logic          cpu_clk_en;
  logic          dump_busy;
  logic [2:0]    fsm_state;

  logic [31:0] dbg_mem [0:NW-1];

  assign dbg_word = dbg_mem[dbg_sel];

  dbg_uart_ctrl #(
    .NUM_WORDS (NW),
    .ADDR_W    (AW),
    .HDR       (8'hA5),
    .TRL       (8'h5A)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_done_tick (rx_done_tick),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_done_tick (tx_done_tick),
    .dbg_sel      (dbg_sel),
    .dbg_word     (dbg_word),
    .cpu_clk_en   (cpu_clk_en),
    .dump_busy    (dump_busy),
    .fsm_state    (fsm_state)
  );

  // bookkeeping
  int n_tests;
  int n_fail;

  // responder-owned observations
  logic [7:0] cap_q[$];
  int         stab_viol;
  int         ovl_viol;
  int         spur_served;
  time        last_done_t;
  logic [7:0] bad_got;
  logic [7:0] bad_exp;

  // test-owned controls
  int tx_delay;
  int spur_req;

  // ---------------------------------------------------------------------------
  // Transmitter responder
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] held;
    int         cnt;
    bit         outstanding;
    bit         was_out;
    tx_done_tick = 1'b0;
    held         = 8'h00;
    cnt          = 0;
    outstanding  = 1'b0;
    stab_viol    = 0;
    ovl_viol     = 0;
    spur_served  = 0;
    last_done_t  = 0;
    bad_got      = 8'h00;
    bad_exp      = 8'h00;
    forever begin
      @(negedge clk);
      tx_done_tick = 1'b0;
      if (!reset) begin
        outstanding = 1'b0;
      end else begin
        was_out = outstanding;
        if (outstanding) begin
          if (tx_data !== held) begin
            stab_viol++;
            bad_got = tx_data;
            bad_exp = held;
          end
          if (cnt == 0) begin
            tx_done_tick = 1'b1;
            outstanding  = 1'b0;
            last_done_t  = $time;
          end else begin
            cnt--;
          end
        end else if (spur_served < spur_req) begin
          tx_done_tick = 1'b1;
          spur_served++;
        end
        if (tx_start === 1'b1) begin
          if (was_out) ovl_viol++;
          cap_q.push_back(tx_data);
          held        = tx_data;
          outstanding = 1'b1;
          cnt         = tx_delay;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data      = b;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic randomize_mem();
    for (int w = 0; w < NW; w++) dbg_mem[w] = $urandom;
  endtask

  // Runs one complete dump and compares the captured frame with the model.
  task automatic run_dump(input string name, input bit noise, input int halt_at);
    logic [7:0] exp_q[$];
    logic [7:0] noise_tab [0:4];
    logic [31:0] w_val;
    int base;
    int sv0;
    int ov0;
    int c;
    bit fell;
    noise_tab = '{8'h64, 8'h41, 8'h00, 8'hFF, 8'h64};
    exp_q.push_back(8'hA5);
    for (int w = 0; w < NW; w++) begin
      w_val = dbg_mem[w];
      for (int k = 0; k < 4; k++) exp_q.push_back(8'((w_val >> (24 - 8 * k)) & 32'hFF));
    end
    exp_q.push_back(8'h5A);
    base = cap_q.size();
    sv0  = stab_viol;
    ov0  = ovl_viol;

    @(negedge clk);
    n_tests++;
    if (dump_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_before_cmd got %b exp 0", name, dump_busy);
    end
    rx_data      = 8'h64;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    n_tests++;
    if (dump_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_after_cmd got %b exp 1", name, dump_busy);
    end

    fell = 1'b0;
    c    = 0;
    while (!fell && c < 20000) begin
      @(negedge clk);
      rx_done_tick = 1'b0;
      if (halt_at >= 0 && c == halt_at + 1) begin
        n_tests++;
        if (cpu_clk_en !== 1'b0) begin
          n_fail++;
          $display("FAIL %s halt_mid_dump cpu_clk_en got %b exp 0", name, cpu_clk_en);
        end
      end
      if (!dump_busy) begin
        fell = 1'b1;
      end else if (halt_at >= 0 && c == halt_at) begin
        rx_data      = 8'h68;
        rx_done_tick = 1'b1;
      end else if (noise && $urandom_range(0, 3) == 0) begin
        rx_data      = noise_tab[$urandom_range(0, 4)];
        rx_done_tick = 1'b1;
      end
      c++;
    end
    rx_done_tick = 1'b0;

    n_tests++;
    if (!fell) begin
      n_fail++;
      $display("FAIL %s dump_timeout busy got %b exp 0 after %0d cycles", name, dump_busy, c);
    end
    n_tests++;
    if ($time - last_done_t != 10) begin
      n_fail++;
      $display("FAIL %s busy_fall_time got %0t exp %0t", name, $time - last_done_t, 10);
    end
    n_tests++;
    if (cap_q.size() - base != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s frame_len got %0d exp %0d", name, cap_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < cap_q.size()) begin
        n_tests++;
        if (cap_q[base + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s byte[%0d] got %h exp %h", name, i, cap_q[base + i], exp_q[i]);
        end
      end
    end
    n_tests++;
    if (stab_viol != sv0) begin
      n_fail++;
      $display("FAIL %s tx_data_stable got %h exp %h (%0d events)", name, bad_got, bad_exp, stab_viol - sv0);
    end
    n_tests++;
    if (ovl_viol != ov0) begin
      n_fail++;
      $display("FAIL %s tx_start_outstanding got %0d exp 0", name, ovl_viol - ov0);
    end
    n_tests++;
    if (dbg_sel !== '0) begin
      n_fail++;
      $display("FAIL %s dbg_sel_end got %0d exp 0", name, dbg_sel);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset        = 1'b0;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (cpu_clk_en !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_clk_en got %b exp 0", cpu_clk_en); end
    n_tests++;
    if (tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_tx_start got %b exp 0", tx_start); end
    n_tests++;
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    n_tests++;
    if (dbg_sel !== '0) begin n_fail++; $display("FAIL reset_dbg_sel got %0d exp 0", dbg_sel); end
    n_tests++;
    if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL reset_dump_busy got %b exp 0", dump_busy); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_step();
    for (int r = 0; r < 2; r++) begin
      send_byte(8'h73);
      n_tests++;
      if (cpu_clk_en !== 1'b1) begin n_fail++; $display("FAIL step_on[%0d] got %b exp 1", r, cpu_clk_en); end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        n_tests++;
        if (cpu_clk_en !== 1'b0) begin n_fail++; $display("FAIL step_off[%0d.%0d] got %b exp 0", r, k, cpu_clk_en); end
      end
    end
    // two 's' bytes on consecutive cycles: the second lands while a step is pending
    @(negedge clk);
    rx_data      = 8'h73;
    rx_done_tick = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cpu_clk_en !== 1'b1) begin n_fail++; $display("FAIL step_b2b_on got %b exp 1", cpu_clk_en); end
    @(negedge clk);
    rx_done_tick = 1'b0;
    n_tests++;
    if (cpu_clk_en !== 1'b0) begin n_fail++; $display("FAIL step_b2b_off got %b exp 0", cpu_clk_en); end
    @(negedge clk);
    n_tests++;
    if (cpu_clk_en !== 1'b0) begin n_fail++; $display("FAIL step_b2b_off2 got %b exp 0", cpu_clk_en); end
  endtask

  task automatic test_run_halt();
    send_byte(8'h72);
    n_tests++;
    if (cpu_clk_en !== 1'b1) begin n_fail++; $display("FAIL run_on got %b exp 1", cpu_clk_en); end
    send_byte(8'h73);
    n_tests++;
    if (cpu_clk_en !== 1'b1) begin n_fail++; $display("FAIL run_step_ignored got %b exp 1", cpu_clk_en); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_tests++;
      if (cpu_clk_en !== 1'b1) begin n_fail++; $display("FAIL run_hold[%0d] got %b exp 1", k, cpu_clk_en); end
    end
    send_byte(8'h41);
    n_tests++;
    if (cpu_clk_en !== 1'b1) begin n_fail++; $display("FAIL run_other_byte got %b exp 1", cpu_clk_en); end
    send_byte(8'h68);
    n_tests++;
    if (cpu_clk_en !== 1'b0) begin n_fail++; $display("FAIL halt_off got %b exp 0", cpu_clk_en); end
  endtask

  // Random command stream; the model tracks the run flag and whether the
  // previous cycle issued a step.
  task automatic test_random_cmds();
    logic [7:0] tab [0:5];
    bit run_m;
    bit step_prev;
    bit exp_en;
    bit fire;
    bit v;
    logic [7:0] b;
    tab = '{8'h72, 8'h68, 8'h73, 8'h73, 8'h41, 8'h00};
    send_byte(8'h68);
    @(negedge clk);
    run_m     = 1'b0;
    step_prev = 1'b0;
    exp_en    = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n_tests++;
      if (cpu_clk_en !== exp_en) begin
        n_fail++;
        $display("FAIL rand_cmd[%0d] cpu_clk_en got %b exp %b", i, cpu_clk_en, exp_en);
      end
      v = ($urandom_range(0, 2) != 0);
      b = tab[$urandom_range(0, 5)];
      rx_data      = b;
      rx_done_tick = v;
      fire = v && (b == 8'h73) && !run_m && !step_prev;
      if (v && b == 8'h72) run_m = 1'b1;
      if (v && b == 8'h68) run_m = 1'b0;
      exp_en    = run_m | fire;
      step_prev = fire;
    end
    @(negedge clk);
    rx_done_tick = 1'b0;
    n_tests++;
    if (cpu_clk_en !== exp_en) begin
      n_fail++;
      $display("FAIL rand_cmd_last cpu_clk_en got %b exp %b", cpu_clk_en, exp_en);
    end
    send_byte(8'h68);
  endtask

  task automatic test_dump_fixed();
    tx_delay   = 0;
    dbg_mem[0] = 32'h11223344;
    dbg_mem[1] = 32'hDEADBEEF;
    dbg_mem[2] = 32'hCAFEF00D;
    dbg_mem[3] = 32'h01020304;
    run_dump("dump_fixed", 1'b0, -1);
  endtask

  task automatic test_ignored_during_dump();
    tx_delay = 1;
    randomize_mem();
    send_byte(8'h72);
    n_tests++;
    if (cpu_clk_en !== 1'b1) begin n_fail++; $display("FAIL ign_run_on got %b exp 1", cpu_clk_en); end
    run_dump("dump_ignored", 1'b1, 10);
    n_tests++;
    if (cpu_clk_en !== 1'b0) begin n_fail++; $display("FAIL ign_halt_after got %b exp 0", cpu_clk_en); end
  endtask

  task automatic test_slow_tx();
    int n0;
    tx_delay = 500;
    randomize_mem();
    run_dump("dump_slow", 1'b0, -1);
    tx_delay = 0;
    // spurious done while idle must not start anything
    n0 = cap_q.size();
    spur_req++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_tests++;
      if (tx_start !== 1'b0 || dump_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL spurious_done[%0d] tx_start %b busy %b exp 0 0", k, tx_start, dump_busy);
      end
    end
    n_tests++;
    if (cap_q.size() != n0) begin n_fail++; $display("FAIL spurious_bytes got %0d exp 0", cap_q.size() - n0); end
  endtask

  task automatic test_reset_mid_dump();
    int base;
    int n_at_rst;
    int c;
    tx_delay = 2;
    randomize_mem();
    base = cap_q.size();
    send_byte(8'h64);
    c = 0;
    while (cap_q.size() - base < 5 && c < 500) begin
      @(negedge clk);
      c++;
    end
    n_tests++;
    if (cap_q.size() - base < 5) begin
      n_fail++;
      $display("FAIL rst_mid_wait got %0d bytes exp 5", cap_q.size() - base);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (dump_busy !== 1'b0 || dbg_sel !== '0 || tx_start !== 1'b0 || tx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_state busy %b sel %0d start %b data %h exp 0 0 0 00",
               dump_busy, dbg_sel, tx_start, tx_data);
    end
    n_at_rst = cap_q.size();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_tests++;
      if (dump_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy[%0d] got %b exp 0", k, dump_busy); end
    end
    n_tests++;
    if (cap_q.size() != n_at_rst) begin
      n_fail++;
      $display("FAIL rst_mid_no_tx got %0d extra bytes exp 0", cap_q.size() - n_at_rst);
    end
    run_dump("dump_after_rst", 1'b0, -1);
  endtask

  task automatic test_random_dumps();
    for (int r = 0; r < 4; r++) begin
      tx_delay = $urandom_range(0, 6);
      randomize_mem();
      run_dump($sformatf("dump_rand%0d", r), 1'b1, -1);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    n_tests      = 0;
    n_fail       = 0;
    tx_delay     = 0;
    spur_req     = 0;
    reset        = 1'b0;
    rx_data      = 8'h00;
    rx_done_tick = 1'b0;
    for (int w = 0; w < NW; w++) dbg_mem[w] = 32'h0;

    test_reset();
    test_step();
    test_run_halt();
    test_random_cmds();
    test_dump_fixed();
    test_ignored_during_dump();
    test_slow_tx();
    test_reset_mid_dump();
    test_random_dumps();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dbg_uart_ctrl.md
Name: dbg_uart_ctrl

Overview:
Debug command controller between the UART byte stream and the pipeline debug taps. It decodes single-byte commands received from the UART receiver, gates the CPU clock enable (run, halt, single-step), and sequences a dump of the pipeline debug words to the UART transmitter as a framed byte stream. It replaces direct FIFO loopback with a controlled transmit scheduler.

Parameters:
NUM_WORDS, 64, number of 32-bit debug words in one dump (1..2^ADDR_W)
ADDR_W, 6, width of the debug word select
HDR, 8'hA5, frame header byte sent before a dump
TRL, 8'h5A, frame trailer byte sent after a dump

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
rx_data  in  8  received byte, valid while rx_done_tick=1
rx_done_tick  in  1  one-cycle pulse per received byte
tx_data  out  8  byte to transmit
tx_start  out  1  one-cycle pulse: transmitter loads tx_data
tx_done_tick  in  1  one-cycle pulse: transmitter finished the byte
dbg_sel  out  ADDR_W  debug word select to external tap mux
dbg_word  in  32  selected debug word, combinational from dbg_sel
cpu_clk_en  out  1  pipeline clock enable
dump_busy  out  1  high while a dump frame is in progress

Behaviour:
- Reset (reset=0, async): state IDLE, cpu_clk_en=0 (halted), tx_start=0, tx_data=0, dbg_sel=0, dump_busy=0, byte index 0, run flag 0.
- Commands sampled only on rx_done_tick; non-command bytes are ignored with no effect.
  - 0x72 'r': run flag=1; cpu_clk_en=1 from the next cycle.
  - 0x68 'h': run flag=0; cpu_clk_en=0 from the next cycle. Accepted in any state; it does not abort a dump.
  - 0x73 's': accepted only when halted and no step is pending. cpu_clk_en=1 for exactly one cycle, starting the cycle after the command. Ignored while running.
  - 0x64 'd': starts a dump when dump_busy=0. Ignored while dump_busy=1; it is not queued.
- cpu_clk_en = run flag OR step pulse, registered.
- Dump FSM states:
  - IDLE: on 'd', go to HDR_TX, with dump_busy=1 from the next cycle.
  - HDR_TX: drive tx_data=HDR, pulse tx_start for one cycle, go to WAIT.
  - LATCH: dbg_sel is already stable from the previous cycle. Register dbg_word into a 32-bit shadow and set byte index=0.
  - BYTE_TX: tx_data = shadow byte[3-index], so MSB is sent first. Pulse tx_start, go to WAIT.
  - WAIT: hold until tx_done_tick, then:
    - after header: dbg_sel=0, go to LATCH;
    - after data byte with index<3: index+1, go to BYTE_TX;
    - after index 3 with dbg_sel<NUM_WORDS-1: dbg_sel+1, go to LATCH;
    - after index 3 of the last word: go to TRL_TX.
  - TRL_TX: tx_data=TRL, pulse tx_start, go to DONE_WAIT.
  - DONE_WAIT: on tx_done_tick, go to IDLE with dump_busy=0 and dbg_sel=0.
- Frame length: 4*NUM_WORDS+2 bytes. tx_start is never asserted while a byte is outstanding.
- tx_data is held stable from the tx_start cycle until tx_done_tick.
- Each word is snapshotted in LATCH. If the CPU runs during a dump, each word reflects its own latch cycle; there is no whole-frame coherence.
- A tx_done_tick outside WAIT or DONE_WAIT is ignored.
- rx_done_tick and tx_done_tick in the same cycle are both processed.
- dbg_sel wraps only through the explicit reset to 0 at dump end. Counter widths must not overflow when NUM_WORDS=2^ADDR_W.
- Asynchronous reset mid-dump returns all state to reset values immediately. A partially sent frame is abandoned and no trailer is sent.

Test Plan:
- After reset release, send 0x73 → cpu_clk_en high for exactly 1 cycle. Send 0x73 again → another single 1-cycle pulse.
- Send 0x72, then 0x73 → cpu_clk_en stays 1 with no glitch. Send 0x68 → cpu_clk_en=0 the cycle after rx_done_tick.
- NUM_WORDS=2, word0=0x11223344, word1=0xDEADBEEF, 0x64 → bytes A5 11 22 33 44 DE AD BE EF 5A. dump_busy high from the cycle after the command until the cycle after the last tx_done_tick.
- During a dump, send 0x64 and 0x41 → no restart, frame unchanged. Send 0x68 mid-dump → cpu_clk_en=0 and the frame completes intact.
- Delay tx_done_tick by 500 cycles per byte → tx_start pulses once per byte and tx_data is stable across each wait. A spurious tx_done_tick in IDLE causes no output.
- Assert reset after the 5th byte of a dump → dump_busy=0, dbg_sel=0, and no further tx_start. A new 0x64 then yields a full frame starting with A5.
